// File: rtl/ocp_rd_resp_back_end_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ocp_rd_resp_back_end_pkg                                        |
// | Purpose  : Shared OCP response codes and packed AXI-side packet types.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package ocp_rd_resp_back_end_pkg;

    localparam int c_DATA_W    = 32;
    localparam int c_ID_W      = 4;
    localparam int c_ADDR_W    = 32;
    localparam int c_MAX_BEATS = 16;
    localparam int c_LEN_W     = $clog2(c_MAX_BEATS);

    typedef enum logic [1:0] {
        OCP_NULL = 2'b00,
        OCP_DVA  = 2'b01,
        OCP_FAIL = 2'b10,
        OCP_ERR  = 2'b11
    } ocp_resp_e;

    // Word 0 occupies the least significant DATA_W bits of the packet.
    typedef struct packed {
        logic [c_ID_W-1:0]                     id;
        logic [c_LEN_W-1:0]                    length;
        logic [c_MAX_BEATS-1:0][c_DATA_W-1:0]  d;
    } axi_data_pkt;

    typedef struct packed {
        logic [c_ID_W-1:0]   id;
        logic [c_ADDR_W-1:0] addr;
        logic [c_LEN_W-1:0]  length;
    } axi_addr_pkt;

    typedef struct packed {
        axi_addr_pkt a;
        axi_data_pkt w;
    } axi_addr_data_pkt;

endpackage
`default_nettype wire

// File: rtl/ocp_rd_resp_back_end.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ocp_rd_resp_back_end                                            |
// | Purpose  : Serialises one packed read packet into 1..MAX_BEATS OCP DVA     |
// |            beats, honouring MRespAccept backpressure.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ocp_rd_resp_back_end
    import ocp_rd_resp_back_end_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ID_W      = c_ID_W,
    parameter int MAX_BEATS = c_MAX_BEATS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_resp_pkt_vld,
    input  axi_data_pkt        rd_resp_pkt,
    output logic               rd_resp_pkt_rdy,
    output logic [1:0]         SResp,
    output logic [DATA_W-1:0]  SData,
    output logic               SRespLast,
    output logic [ID_W-1:0]    STagID,
    input  logic               MRespAccept
);

    localparam int c_CNT_W = $clog2(MAX_BEATS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    state_e                           r_state, w_state_nxt;
    ocp_resp_e                        r_sresp, w_sresp_nxt;
    logic [DATA_W-1:0]                r_sdata, w_sdata_nxt;
    logic                             r_last,  w_last_nxt;
    logic [ID_W-1:0]                  r_tag,   w_tag_nxt;
    logic [c_CNT_W-1:0]               r_bcnt,  w_bcnt_nxt;
    logic [c_CNT_W-1:0]               r_len;
    logic [MAX_BEATS-1:0][DATA_W-1:0] r_data;

    logic               w_beat_acc;
    logic               w_take;
    logic [c_CNT_W-1:0] w_bcnt_inc;

    assign w_beat_acc      = (r_sresp == OCP_DVA) && MRespAccept;
    assign rd_resp_pkt_rdy = !rst && ((r_state == S_IDLE) || (w_beat_acc && r_last));
    assign w_take          = rd_resp_pkt_vld && rd_resp_pkt_rdy;
    assign w_bcnt_inc      = r_bcnt + 1'b1;

    assign SResp     = r_sresp;
    assign SData     = r_sdata;
    assign SRespLast = r_last;
    assign STagID    = r_tag;

    // Beat 0 is driven straight from the incoming packet so the first beat
    // needs no extra cycle; later beats come from the holding register.
    always_comb begin
        w_state_nxt = r_state;
        w_sresp_nxt = r_sresp;
        w_sdata_nxt = r_sdata;
        w_last_nxt  = r_last;
        w_tag_nxt   = r_tag;
        w_bcnt_nxt  = r_bcnt;
        if (w_take) begin
            w_state_nxt = S_SEND;
            w_sresp_nxt = OCP_DVA;
            w_sdata_nxt = rd_resp_pkt.d[0];
            w_tag_nxt   = rd_resp_pkt.id;
            w_last_nxt  = (rd_resp_pkt.length == '0);
            w_bcnt_nxt  = '0;
        end else if (r_state == S_SEND && w_beat_acc) begin
            if (!r_last) begin
                w_bcnt_nxt  = w_bcnt_inc;
                w_sdata_nxt = r_data[w_bcnt_inc];
                w_last_nxt  = (w_bcnt_inc == r_len);
            end else begin
                w_state_nxt = S_IDLE;
                w_sresp_nxt = OCP_NULL;
                w_last_nxt  = 1'b0;
                w_bcnt_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sresp <= OCP_NULL;
            r_sdata <= '0;
            r_last  <= 1'b0;
            r_tag   <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sresp <= w_sresp_nxt;
            r_sdata <= w_sdata_nxt;
            r_last  <= w_last_nxt;
            r_tag   <= w_tag_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    // Holding copy lets upstream move on as soon as the packet is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_data <= '0;
        end else if (w_take) begin
            r_len  <= rd_resp_pkt.length;
            r_data <= rd_resp_pkt.d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ocp_rd_resp_back_end.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ocp_rd_resp_back_end                                         |
// | Purpose  : Table, directed and random checks against a beat-queue model.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ocp_rd_resp_back_end;
    import ocp_rd_resp_back_end_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_resp_pkt_vld;
    axi_data_pkt rd_resp_pkt;
    logic        rd_resp_pkt_rdy;
    logic [1:0]  SResp;
    logic [31:0] SData;
    logic        SRespLast;
    logic [3:0]  STagID;
    logic        MRespAccept;

    int checks = 0;
    int errors = 0;

    ocp_rd_resp_back_end dut (
        .clk             (clk),
        .rst             (rst),
        .rd_resp_pkt_vld (rd_resp_pkt_vld),
        .rd_resp_pkt     (rd_resp_pkt),
        .rd_resp_pkt_rdy (rd_resp_pkt_rdy),
        .SResp           (SResp),
        .SData           (SData),
        .SRespLast       (SRespLast),
        .STagID          (STagID),
        .MRespAccept     (MRespAccept)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic        last;
        logic [3:0]  tag;
        logic        rdy;
    } samp_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [31:0] base;
        logic        acc;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        logic        e_last;
        logic [3:0]  e_tag;
        logic        e_rdy;
    } vec_t;

    // Reference model: queue of beats still owed to the master, head = on the wire.
    beat_t       q[$];
    logic [31:0] m_data;
    logic [3:0]  m_tag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic axi_data_pkt mk_pkt(input logic [3:0] id, input logic [3:0] len,
                                           input logic [31:0] base);
        axi_data_pkt p;
        p = '0;
        p.id = id;
        p.length = len;
        for (int i = 0; i < 16; i++) p.d[i] = base + 32'(i);
        return p;
    endfunction

    task automatic cycle(input logic r, input logic v, input axi_data_pkt p, input logic a,
                         output samp_t s);
        logic busy, e_rdy, e_last;
        rst = r;
        rd_resp_pkt_vld = v;
        rd_resp_pkt = p;
        MRespAccept = a;
        #1;
        busy   = (q.size() > 0);
        e_last = 1'b0;
        if (busy) e_last = q[0].last;
        e_rdy  = !r && (!busy || (a && e_last));
        s = '{SResp, SData, SRespLast, STagID, rd_resp_pkt_rdy};
        chk("sresp", 32'(SResp), busy ? 32'(OCP_DVA) : 32'(OCP_NULL));
        chk("sdata", SData, m_data);
        chk("last",  32'(SRespLast), 32'(e_last));
        chk("tag",   32'(STagID), 32'(m_tag));
        chk("rdy",   32'(rd_resp_pkt_rdy), 32'(e_rdy));
        @(posedge clk);
        if (r) begin
            q.delete();
            m_data = '0;
            m_tag  = '0;
        end else begin
            if (busy && a) void'(q.pop_front());
            if (v && e_rdy)
                for (int i = 0; i <= int'(p.length); i++)
                    q.push_back('{p.d[i], p.id, (i == int'(p.length))});
            if (q.size() > 0) begin
                m_data = q[0].data;
                m_tag  = q[0].id;
            end
        end
        #1;
    endtask

    task automatic drain();
        samp_t s;
        for (int n = 0; n < 40 && q.size() > 0; n++) cycle(1'b0, 1'b0, '0, 1'b1, s);
        chk("drain_timeout", q.size(), 0);
    endtask

    vec_t tbl[13];

    initial begin
        samp_t       s;
        axi_data_pkt p, pn;
        int          acc_n, stall, dva, acc_e, taken, pending;
        logic        a, e_rdy;

        tbl[0]  = '{1, 0, 0, 0, 0,            1, 2'd0, 32'h0,         0, 4'd0, 0};
        tbl[1]  = '{0, 1, 3, 0, 32'hA5A5_0000, 1, 2'd0, 32'h0,         0, 4'd0, 1};
        tbl[2]  = '{0, 0, 0, 0, 0,            1, 2'd1, 32'hA5A5_0000, 1, 4'd3, 1};
        tbl[3]  = '{0, 0, 0, 0, 0,            1, 2'd0, 32'hA5A5_0000, 0, 4'd3, 1};
        tbl[4]  = '{0, 1, 5, 3, 32'h1,        1, 2'd0, 32'hA5A5_0000, 0, 4'd3, 1};
        tbl[5]  = '{0, 0, 0, 0, 0,            1, 2'd1, 32'h1,         0, 4'd5, 0};
        tbl[6]  = '{0, 0, 0, 0, 0,            1, 2'd1, 32'h2,         0, 4'd5, 0};
        tbl[7]  = '{0, 0, 0, 0, 0,            1, 2'd1, 32'h3,         0, 4'd5, 0};
        tbl[8]  = '{0, 1, 1, 1, 32'h100,      1, 2'd1, 32'h4,         1, 4'd5, 1};
        tbl[9]  = '{0, 1, 2, 0, 32'h200,      1, 2'd1, 32'h100,       0, 4'd1, 0};
        tbl[10] = '{0, 1, 2, 0, 32'h200,      1, 2'd1, 32'h101,       1, 4'd1, 1};
        tbl[11] = '{0, 0, 0, 0, 0,            1, 2'd1, 32'h200,       1, 4'd2, 1};
        tbl[12] = '{0, 0, 0, 0, 0,            1, 2'd0, 32'h200,       0, 4'd2, 1};

        rst = 1'b1; rd_resp_pkt_vld = 1'b0; rd_resp_pkt = '0; MRespAccept = 1'b0;
        m_data = '0; m_tag = '0;
        repeat (2) @(posedge clk);
        #1;

        // Single beat, 4-beat burst, back-to-back packets with vld held.
        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].vld, mk_pkt(tbl[i].id, tbl[i].len, tbl[i].base),
                  tbl[i].acc, s);
            chk($sformatf("tbl%0d_resp", i), 32'(s.resp), 32'(tbl[i].e_resp));
            chk($sformatf("tbl%0d_data", i), s.data, tbl[i].e_data);
            chk($sformatf("tbl%0d_last", i), 32'(s.last), 32'(tbl[i].e_last));
            chk($sformatf("tbl%0d_tag",  i), 32'(s.tag), 32'(tbl[i].e_tag));
            chk($sformatf("tbl%0d_rdy",  i), 32'(s.rdy), 32'(tbl[i].e_rdy));
        end

        // 16-beat packet with 3-cycle stalls on beats 2 and 9.
        p = mk_pkt(4'hC, 4'd15, 32'hC000_0000);
        cycle(1'b0, 1'b1, p, 1'b1, s);
        acc_n = 0; stall = 0; dva = 0;
        for (int c = 0; c < 40 && acc_n < 16; c++) begin
            a = 1'b1;
            if ((acc_n == 1 || acc_n == 8) && stall < 3) begin
                a = 1'b0;
                stall++;
            end
            cycle(1'b0, 1'b0, '0, a, s);
            if (s.resp == 2'b01) begin
                dva++;
                if (a) begin
                    acc_n++;
                    stall = 0;
                end
            end
        end
        chk("len15_beats", acc_n, 16);
        chk("len15_cycles", dva, 22);

        // Reset while the third beat of an 8-beat packet is on the wire.
        p = mk_pkt(4'h6, 4'd7, 32'h700);
        cycle(1'b0, 1'b1, p, 1'b1, s);
        cycle(1'b0, 1'b0, '0, 1'b1, s);
        cycle(1'b0, 1'b0, '0, 1'b1, s);
        cycle(1'b1, 1'b0, '0, 1'b1, s);
        chk("pre_rst_data", s.data, 32'h702);
        cycle(1'b0, 1'b0, '0, 1'b1, s);
        chk("post_rst_resp", 32'(s.resp), 32'(OCP_NULL));
        chk("post_rst_data", s.data, 32'h0);
        p = mk_pkt(4'h7, 4'd2, 32'h800);
        cycle(1'b0, 1'b1, p, 1'b0, s);
        cycle(1'b0, 1'b0, '0, 1'b1, s);
        chk("restart_d0", s.data, 32'h800);
        drain();

        // Packet offered while busy is taken exactly once, on the last-beat accept.
        p  = mk_pkt(4'h9, 4'd3, 32'h900);
        pn = mk_pkt(4'hA, 4'd2, 32'hA00);
        cycle(1'b0, 1'b1, p, 1'b1, s);
        acc_e = 0; taken = 0;
        for (int n = 0; n < 40 && taken == 0; n++) begin
            a = 1'($urandom_range(0, 1));
            e_rdy = (acc_e == 3) && a;
            cycle(1'b0, 1'b1, pn, a, s);
            chk("busy_rdy", 32'(s.rdy), 32'(e_rdy));
            if (s.rdy) taken++;
            if (a) acc_e++;
        end
        chk("busy_takes", taken, 1);
        drain();

        // Random traffic with occasional resets.
        pending = 0;
        pn = '0;
        for (int n = 0; n < 1500; n++) begin
            logic r, v;
            r = ($urandom_range(0, 99) == 0);
            if (!pending && $urandom_range(0, 2) != 0) begin
                pn.id = 4'($urandom);
                pn.length = 4'($urandom);
                for (int i = 0; i < 16; i++) pn.d[i] = $urandom;
                pending = 1;
            end
            v = (pending != 0);
            a = ($urandom_range(0, 3) != 0);
            cycle(r, v, pn, a, s);
            if (r || (v && s.rdy)) pending = 0;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
